// File: rtl/weight_tile_loader_if.sv
// Handshake and memory/FIFO bus of the weight tile loader.
// The controller side is "master"; the loader itself is "slave".
interface weight_tile_loader_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          start;
    logic [AW-1:0] tile_base_n;
    logic [AW-1:0] tile_base_m;
    logic          busy;
    logic          done;
    logic          ram_rd_en;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] data_from_ram;
    logic          fifo_push;
    logic [DW-1:0] data_to_fifo;
    logic          fifo_almost_full;

    modport master (
        output start, tile_base_n, tile_base_m, data_from_ram, fifo_almost_full,
        input  busy, done, ram_rd_en, ram_addr, fifo_push, data_to_fifo
    );

    modport slave (
        input  start, tile_base_n, tile_base_m, data_from_ram, fifo_almost_full,
        output busy, done, ram_rd_en, ram_addr, fifo_push, data_to_fifo
    );
endinterface

// File: rtl/weight_tile_loader.sv
// Streams a Tn x Tm x K x K weight tile from W[N][M][K][K] RAM into the weight FIFO,
// zero-padding or skipping out-of-range entries, with a read-latency-matched push pipeline.
module weight_tile_loader #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int N        = 32,
    parameter int M        = 32,
    parameter int K        = 3,
    parameter int Tn       = 8,
    parameter int Tm       = 8,
    parameter int RD_LAT   = 2,
    parameter int PAD_MODE = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    weight_tile_loader_if.slave  io_bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam int KW  = $clog2(K + 1);
    localparam int TMW = $clog2(Tm + 1);
    localparam int TNW = $clog2(Tn + 1);

    localparam logic [KW-1:0]  K_LAST  = KW'(K - 1);
    localparam logic [TMW-1:0] TM_LAST = TMW'(Tm - 1);
    localparam logic [TNW-1:0] TN_LAST = TNW'(Tn - 1);

    logic [1:0]        r_state;
    logic [AW-1:0]     r_base_n;
    logic [AW-1:0]     r_base_m;
    logic [KW-1:0]     r_j;
    logic [KW-1:0]     r_i;
    logic [TMW-1:0]    r_tm;
    logic [TNW-1:0]    r_tn;
    logic [AW-1:0]     r_addr_hold;
    logic [RD_LAT-1:0] r_vld;
    logic [RD_LAT-1:0] r_leg;

    logic              w_accept;
    logic              w_step;
    logic              w_last;
    logic              w_legal;
    logic [AW:0]       w_n_sum;
    logic [AW:0]       w_m_sum;
    logic [AW-1:0]     w_n_idx;
    logic [AW-1:0]     w_m_idx;
    logic [AW-1:0]     w_addr;
    logic [RD_LAT-1:0] w_vld_sh;
    logic              w_out_vld;
    logic              w_out_leg;

    assign w_accept = (r_state == S_IDLE) && io_bus.start;
    assign w_step   = (r_state == S_ISSUE) && !io_bus.fifo_almost_full;
    assign w_last   = (r_j == K_LAST) && (r_i == K_LAST) && (r_tm == TM_LAST) && (r_tn == TN_LAST);

    // Legality is evaluated one bit wider so a base near the top of the range cannot wrap into range.
    assign w_n_sum  = {1'b0, r_base_n} + (AW+1)'(r_tn);
    assign w_m_sum  = {1'b0, r_base_m} + (AW+1)'(r_tm);
    assign w_legal  = (w_n_sum < (AW+1)'(N)) && (w_m_sum < (AW+1)'(M));
    assign w_n_idx  = r_base_n + AW'(r_tn);
    assign w_m_idx  = r_base_m + AW'(r_tm);
    assign w_addr   = w_n_idx * AW'(M * K * K) + w_m_idx * AW'(K * K)
                    + AW'(r_i) * AW'(K) + AW'(r_j);

    // Only slots below the output stage matter for "pipeline empty next cycle".
    assign w_vld_sh  = r_vld << 1'b1;
    assign w_out_vld = r_vld[RD_LAT-1];
    assign w_out_leg = r_leg[RD_LAT-1];

    assign io_bus.busy         = (r_state != S_IDLE);
    assign io_bus.done         = (r_state == S_DONE);
    assign io_bus.ram_rd_en    = w_step && w_legal;
    assign io_bus.ram_addr     = (w_step && w_legal) ? w_addr : r_addr_hold;
    assign io_bus.fifo_push    = w_out_vld && ((PAD_MODE != 0) || w_out_leg);
    assign io_bus.data_to_fifo = (w_out_vld && w_out_leg) ? io_bus.data_from_ram : {DW{1'b0}};

    // Control FSM: IDLE -> ISSUE -> DRAIN -> DONE -> IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  r_state <= io_bus.start ? S_ISSUE : S_IDLE;
                S_ISSUE: r_state <= (w_step && w_last) ? S_DRAIN : S_ISSUE;
                S_DRAIN: r_state <= (|w_vld_sh) ? S_DRAIN : S_DONE;
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Tile origin, captured only on an accepted start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_base_n <= {AW{1'b0}};
            r_base_m <= {AW{1'b0}};
        end else if (w_accept) begin
            r_base_n <= io_bus.tile_base_n;
            r_base_m <= io_bus.tile_base_m;
        end
    end

    // Element counters j (fastest), i, tm, tn (slowest) with carry chain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst || w_accept) begin
            r_j  <= {KW{1'b0}};
            r_i  <= {KW{1'b0}};
            r_tm <= {TMW{1'b0}};
            r_tn <= {TNW{1'b0}};
        end else if (w_step) begin
            if (r_j != K_LAST) begin
                r_j <= r_j + KW'(1'b1);
            end else begin
                r_j <= {KW{1'b0}};
                if (r_i != K_LAST) begin
                    r_i <= r_i + KW'(1'b1);
                end else begin
                    r_i <= {KW{1'b0}};
                    if (r_tm != TM_LAST) begin
                        r_tm <= r_tm + TMW'(1'b1);
                    end else begin
                        r_tm <= {TMW{1'b0}};
                        r_tn <= (r_tn != TN_LAST) ? r_tn + TNW'(1'b1) : {TNW{1'b0}};
                    end
                end
            end
        end
    end

    // RAM address holds its last issued value between reads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr_hold <= {AW{1'b0}};
        end else if (w_step && w_legal) begin
            r_addr_hold <= w_addr;
        end
    end

    // Step tags travel RD_LAT cycles to line up with the returning RAM data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld <= {RD_LAT{1'b0}};
            r_leg <= {RD_LAT{1'b0}};
        end else begin
            r_vld[0] <= w_step;
            r_leg[0] <= w_step && w_legal;
            for (int k = 1; k < RD_LAT; k++) begin
                r_vld[k] <= r_vld[k-1];
                r_leg[k] <= r_leg[k-1];
            end
        end
    end
endmodule

// File: doc/weight_tile_loader.md
Name: weight_tile_loader

Overview:
- Next-generation RAM-to-FIFO weight mover for the conv accelerator.
- On `start`, latches a tile origin (n, m) and streams the Tn x Tm x K x K weight tile from on-chip weight RAM, laid out W[N][M][K][K] row-major, into the weight FIFO in kernel order.
- New versus the prior mover: it drives a real RAM address and read enable, and the RAM read latency is parametrised.
- Also new: edge tiles are either zero-padded or compacted (PAD_MODE), with explicit busy/done handshake and drain.

Parameters:
- AW, 32, address/counter width.
- DW, 32, data width.
- N, 32, total input channels (weight dim 0).
- M, 32, total output channels (weight dim 1).
- K, 3, kernel size.
- Tn, 8, tile extent along N.
- Tm, 8, tile extent along M.
- RD_LAT, 2, cycles from ram_rd_en/ram_addr to valid data_from_ram (>=1).
- PAD_MODE, 1, 1 = push zero for out-of-range entries, 0 = skip them entirely.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request; ignored unless idle.
- tile_base_n  in  AW  tile origin along N, sampled on accepted start.
- tile_base_m  in  AW  tile origin along M, sampled on accepted start.
- busy  out  1  high from the cycle after accepted start through the done cycle.
- done  out  1  one-cycle pulse, transfer complete.
- ram_rd_en  out  1  RAM read strobe.
- ram_addr  out  AW  RAM word address.
- data_from_ram  in  DW  RAM read data, valid RD_LAT cycles after ram_rd_en.
- fifo_push  out  1  FIFO write strobe.
- data_to_fifo  out  DW  FIFO write data.
- fifo_almost_full  in  1  FIFO backpressure. The FIFO must assert it with >= RD_LAT+1 free slots.

Behaviour:
- Reset (async, any time, including mid-transfer): state IDLE; busy, done, ram_rd_en, fifo_push = 0; ram_addr and data_to_fifo = 0; counters and in-flight pipeline cleared. After reset, no stale push ever appears.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
  - IDLE --start--> ISSUE. Latch the bases and clear the counters.
  - ISSUE --last element stepped--> DRAIN.
  - DRAIN --in-flight pipeline empty--> DONE.
  - DONE --(1 cycle, done=1)--> IDLE.
- Counters: j (0..K-1, fastest), i (0..K-1), tm (0..Tm-1), tn (0..Tn-1, slowest). Each field wraps to 0 and carries into the next. The last element is tn=Tn-1, tm=Tm-1, i=K-1, j=K-1.
- Step condition: in ISSUE, the counters advance one element per cycle iff fifo_almost_full==0. With almost_full high: no step, no ram_rd_en, state held.
- Legality: legal = (base_n+tn < N) && (base_m+tm < M).
- Per step:
  - legal: ram_rd_en=1, ram_addr = (base_n+tn)*M*K*K + (base_m+tm)*K*K + i*K + j, computed modulo 2^AW.
  - illegal: ram_rd_en=0.
  - Outside steps, ram_rd_en=0 and ram_addr holds its last value.
- Push pipeline:
  - Every step enters an RD_LAT-deep valid/legal shift register.
  - At the output, for a step tag:
    - PAD_MODE=1: fifo_push=1 always; data_to_fifo = legal ? data_from_ram : 0.
    - PAD_MODE=0: fifo_push=legal; data_to_fifo = data_from_ram when pushing.
  - When not pushing, data_to_fifo=0.
- Latency: a step in cycle t produces its push in cycle t+RD_LAT. The first step is in the cycle after start, so the first push is at start+1+RD_LAT with no backpressure.
- Ordering: push order is identical to counter order regardless of stalls.
- Element accounting: total steps = Tn*Tm*K*K per transfer.
- Drain: almost_full during DRAIN does not stop in-flight pushes; the FIFO margin guarantees room.
- Completion: done asserts the cycle after the last push, or after the last step's pipeline slot if it was skipped. busy falls with done.
- start while busy (ISSUE/DRAIN/DONE): ignored, no effect on counters or bases.
- start coincident with done: ignored; a new start is accepted from IDLE on the next cycle.
- Tile bases beyond N or M entirely: PAD_MODE=1 pushes all zeros; PAD_MODE=0 completes with zero pushes, and done still pulses.

Test Plan:
- Interior tile, defaults (N=M=32, K=3, Tn=Tm=8, RD_LAT=2), base (0,0), almost_full=0, RAM model returns data=addr → exactly 576 pushes, data 0..8..., first push at start+3, done one cycle after last push.
- Address order: base_n=8, base_m=0 → first ram_addr=2304, second 2305, element j=0,i=1 at 2307, tm=1 starts at 2313; pushed data matches in order.
- Edge tile: N=M=20, base (16,16).
  - PAD_MODE=1 → 576 pushes, 144 nonzero (tn<4, tm<4), 432 zeros, ram_rd_en count 144.
  - PAD_MODE=0 → 144 pushes, no zeros, same order.
- Backpressure: hold almost_full high for 10 cycles after the 50th step → no ram_rd_en during the hold, the RD_LAT already in flight still push, resumes with the 51st element, total 576, order intact.
- Control races: start pulsed during ISSUE and on the done cycle → ignored, one done only. Start next cycle → second full transfer.
- Reset mid-ISSUE with reads in flight → busy/ram_rd_en/fifo_push low immediately, no pushes after reset release. A subsequent start gives a clean 576-push transfer.
